// File: rtl/game_turn_ctrl.sv
// ============================================================================
// Module   : game_turn_ctrl
// Purpose  : Tic-tac-toe turn controller. Moves a one-hot cursor over the
//            3x3 board, places marks for the player on turn, detects wins
//            and draws, and drives the highlight outputs for the display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_turn_ctrl #(
  parameter logic [11:0] COLOR_X = 12'hF00,
  parameter logic [11:0] COLOR_O = 12'h00F
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic        move_right,
  input  logic        move_down,
  input  logic        confirm,
  output logic [8:0]  square_sel,
  output logic        start_en,
  output logic        choice_en,
  output logic [11:0] square_color,
  output logic [8:0]  board_x,
  output logic [8:0]  board_o,
  output logic [1:0]  winner,
  output logic        game_over
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_COMMIT = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] CURSOR_HOME = 4'd4;

  // Current architectural state; player 0 is X, 1 is O.
  state_t     state;
  logic [3:0] cursor;
  logic       player;

  // Next-state values; the registered outputs are decoded from these so that
  // every output reflects the state entered on the same clock edge.
  state_t     state_nx;
  logic [3:0] cursor_nx;
  logic       player_nx;
  logic [8:0] board_x_nx;
  logic [8:0] board_o_nx;
  logic [1:0] winner_nx;

  logic [8:0] occupied;
  logic [8:0] cursor_bit;
  logic [8:0] cur_board;
  logic       restart;

  // True when the board map contains any complete row, column or diagonal.
  function automatic logic has_line(input logic [8:0] b);
    return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
           (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
           (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
  endfunction

  assign occupied   = board_x | board_o;
  assign cursor_bit = 9'd1 << cursor;
  assign cur_board  = player ? board_o : board_x;
  assign restart    = start_btn && (state == ST_IDLE || state == ST_DONE);

  // Next-state logic: cursor moves, mark placement, line/draw evaluation.
  always_comb begin
    state_nx   = state;
    cursor_nx  = cursor;
    player_nx  = player;
    board_x_nx = board_x;
    board_o_nx = board_o;
    winner_nx  = winner;

    case (state)
      ST_SELECT: begin
        // Confirm wins over both moves even when it lands on a taken square,
        // so a single cycle never carries more than one intended action.
        if (confirm) begin
          if (!occupied[cursor]) begin
            state_nx = ST_COMMIT;
          end
        end else if (move_down) begin
          cursor_nx = (cursor >= 4'd6) ? cursor - 4'd6 : cursor + 4'd3;
        end else if (move_right) begin
          cursor_nx = (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
        end
      end

      ST_COMMIT: begin
        if (player) begin
          board_o_nx = board_o | cursor_bit;
        end else begin
          board_x_nx = board_x | cursor_bit;
        end
        state_nx = ST_CHECK;
      end

      ST_CHECK: begin
        // Only the player who just moved can have completed a line.
        if (has_line(cur_board)) begin
          winner_nx = player ? 2'b10 : 2'b01;
          state_nx  = ST_DONE;
        end else if (&occupied) begin
          winner_nx = 2'b11;
          state_nx  = ST_DONE;
        end else begin
          player_nx = ~player;
          state_nx  = ST_SELECT;
        end
      end

      ST_IDLE, ST_DONE: begin
        state_nx = state;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // A new game may only be started from IDLE or after the previous ended.
    if (restart) begin
      state_nx   = ST_SELECT;
      cursor_nx  = CURSOR_HOME;
      player_nx  = 1'b0;
      board_x_nx = 9'd0;
      board_o_nx = 9'd0;
      winner_nx  = 2'b00;
    end
  end

  // State update and registered output decode; reset overrides everything,
  // including a mark that would otherwise be written in COMMIT.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cursor       <= CURSOR_HOME;
      player       <= 1'b0;
      board_x      <= 9'd0;
      board_o      <= 9'd0;
      winner       <= 2'b00;
      game_over    <= 1'b0;
      start_en     <= 1'b0;
      choice_en    <= 1'b0;
      square_sel   <= 9'd0;
      square_color <= COLOR_X;
    end else begin
      state        <= state_nx;
      cursor       <= cursor_nx;
      player       <= player_nx;
      board_x      <= board_x_nx;
      board_o      <= board_o_nx;
      winner       <= winner_nx;
      game_over    <= (state_nx == ST_DONE);
      start_en     <= (state_nx != ST_IDLE);
      choice_en    <= (state_nx == ST_COMMIT);
      square_sel   <= (state_nx == ST_IDLE || state_nx == ST_DONE) ? 9'd0
                                                                   : (9'd1 << cursor_nx);
      square_color <= player_nx ? COLOR_O : COLOR_X;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_turn_ctrl.sv
// ============================================================================
// Module   : tb_game_turn_ctrl
// Purpose  : Self-checking bench for game_turn_ctrl with a board-level
//            reference model of the game rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_turn_ctrl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1, start_btn = 1'b0, move_right = 1'b0, move_down = 1'b0, confirm = 1'b0;
  logic [8:0]  square_sel, board_x, board_o;
  logic        start_en, choice_en, game_over;
  logic [11:0] square_color;
  logic [1:0]  winner;

  game_turn_ctrl dut (
    .pclk(pclk), .rst(rst), .start_btn(start_btn), .move_right(move_right),
    .move_down(move_down), .confirm(confirm), .square_sel(square_sel),
    .start_en(start_en), .choice_en(choice_en), .square_color(square_color),
    .board_x(board_x), .board_o(board_o), .winner(winner), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase, cursor, player (1=X, 2=O), cells (0 empty), winner (3=draw)
  localparam int P_IDLE = 0, P_SEL = 1, P_COMMIT = 2, P_CHECK = 3, P_DONE = 4;
  int m_phase, m_cur, m_pl, m_win;
  int m_cell [9];
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic bit m_line(int p);
    for (int l = 0; l < 8; l++)
      if (m_cell[lines[l][0]] == p && m_cell[lines[l][1]] == p && m_cell[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < 9; i++) if (m_cell[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [8:0] m_map(int p);
    logic [8:0] v = '0;
    for (int i = 0; i < 9; i++) if (m_cell[i] == p) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [8:0] m_sel();
    logic [8:0] one = 9'd1;
    return one << m_cur;
  endfunction

  function automatic logic [11:0] m_color();
    return (m_pl == 1) ? 12'hF00 : 12'h00F;
  endfunction

  function automatic void m_new_game();
    m_phase = P_SEL; m_cur = 4; m_pl = 1; m_win = 0;
    for (int i = 0; i < 9; i++) m_cell[i] = 0;
  endfunction

  function automatic void m_step(bit r, bit s, bit mr, bit md, bit cf);
    if (r) begin
      m_new_game();
      m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (s) m_new_game();
        P_SEL: begin
          if (cf) begin
            if (m_cell[m_cur] == 0) m_phase = P_COMMIT;
          end else if (md) m_cur = (m_cur + 3) % 9;
          else if (mr) m_cur = (m_cur + 1) % 9;
        end
        P_COMMIT: begin m_cell[m_cur] = m_pl; m_phase = P_CHECK; end
        default: begin
          if (m_line(m_pl)) begin m_win = m_pl; m_phase = P_DONE; end
          else if (m_full()) begin m_win = 3; m_phase = P_DONE; end
          else begin m_pl = 3 - m_pl; m_phase = P_SEL; end
        end
      endcase
    end
  endfunction

  // One clock: drive on the falling edge, advance model at the rising edge, settle.
  task automatic cyc(input bit r, input bit s, input bit mr, input bit md, input bit cf);
    @(negedge pclk);
    rst = r; start_btn = s; move_right = mr; move_down = md; confirm = cf;
    @(posedge pclk);
    m_step(r, s, mr, md, cf);
    #1;
    rst = 0; start_btn = 0; move_right = 0; move_down = 0; confirm = 0;
  endtask

  task automatic new_game();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
  endtask

  task automatic goto_sq(input int sq);
    for (int i = 0; i < 9 && m_cur != sq; i++) cyc(0, 0, 1, 0, 0);
  endtask

  task automatic play(input int sq);
    goto_sq(sq);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0);
    n_total++; if (square_sel !== 9'd0) $display("FAIL reset square_sel got %h want 000", square_sel); else n_pass++;
    n_total++; if (start_en !== 1'b0 || choice_en !== 1'b0) $display("FAIL reset en got %b%b want 00", start_en, choice_en); else n_pass++;
    n_total++; if (winner !== 2'b00 || game_over !== 1'b0) $display("FAIL reset winner got %b/%b want 00/0", winner, game_over); else n_pass++;
    n_total++; if (square_color !== 12'hF00) $display("FAIL reset color got %h want F00", square_color); else n_pass++;
    n_total++; if ((board_x | board_o) !== 9'd0) $display("FAIL reset boards got %h/%h want 0", board_x, board_o); else n_pass++;
  endtask

  task automatic test_start();
    cyc(0, 1, 0, 0, 0);
    n_total++; if (square_sel !== 9'h010) $display("FAIL start square_sel got %h want 010", square_sel); else n_pass++;
    n_total++; if (start_en !== 1'b1) $display("FAIL start start_en got %b want 1", start_en); else n_pass++;
    n_total++; if (square_color !== 12'hF00) $display("FAIL start color got %h want F00", square_color); else n_pass++;
  endtask

  task automatic test_cursor_wrap();
    logic [8:0] exp_sel [4] = '{9'h001, 9'h008, 9'h040, 9'h001};
    goto_sq(8);
    n_total++; if (square_sel !== 9'h100) $display("FAIL cursor8 square_sel got %h want 100", square_sel); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) cyc(0, 0, 1, 0, 0); else cyc(0, 0, 0, 1, 0);
      n_total++;
      if (square_sel !== exp_sel[i]) $display("FAIL wrap step %0d square_sel got %h want %h", i, square_sel, exp_sel[i]);
      else n_pass++;
    end
  endtask

  task automatic test_occupied();
    new_game();
    cyc(0, 0, 0, 0, 1);
    n_total++; if (choice_en !== 1'b1) $display("FAIL commit choice_en got %b want 1", choice_en); else n_pass++;
    cyc(0, 0, 0, 0, 0);
    n_total++; if (square_color !== 12'hF00) $display("FAIL check-phase color got %h want F00", square_color); else n_pass++;
    cyc(0, 0, 0, 0, 0);
    n_total++; if (square_color !== 12'h00F) $display("FAIL toggle color got %h want 00F", square_color); else n_pass++;
    cyc(0, 0, 0, 0, 1);
    n_total++; if (choice_en !== 1'b0) $display("FAIL occupied choice_en got %b want 0", choice_en); else n_pass++;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_total++; if (board_x !== 9'h010 || board_o !== 9'd0) $display("FAIL occupied boards got %h/%h want 010/000", board_x, board_o); else n_pass++;
    n_total++; if (square_color !== 12'h00F) $display("FAIL occupied color got %h want 00F", square_color); else n_pass++;
  endtask

  task automatic test_win();
    int seq [5] = '{0, 3, 1, 4, 2};
    new_game();
    foreach (seq[i]) play(seq[i]);
    n_total++; if (winner !== 2'b01 || game_over !== 1'b1) $display("FAIL win winner got %b/%b want 01/1", winner, game_over); else n_pass++;
    n_total++; if (square_sel !== 9'd0 || start_en !== 1'b1) $display("FAIL done outputs got %h/%b want 000/1", square_sel, start_en); else n_pass++;
    play(5);
    cyc(0, 0, 1, 1, 1);
    n_total++; if (board_x !== 9'h007 || board_o !== 9'h018 || winner !== 2'b01)
      $display("FAIL done hold got %h/%h/%b want 007/018/01", board_x, board_o, winner); else n_pass++;
  endtask

  task automatic test_draw();
    int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    new_game();
    foreach (seq[i]) play(seq[i]);
    n_total++; if (winner !== 2'b11 || game_over !== 1'b1) $display("FAIL draw winner got %b/%b want 11/1", winner, game_over); else n_pass++;
    n_total++; if (board_x !== 9'h18D || board_o !== 9'h072) $display("FAIL draw boards got %h/%h want 18D/072", board_x, board_o); else n_pass++;
    cyc(0, 1, 0, 0, 0);
    n_total++; if ((board_x | board_o) !== 9'd0 || winner !== 2'b00) $display("FAIL restart boards got %h/%h/%b want 0", board_x, board_o, winner); else n_pass++;
    n_total++; if (square_sel !== 9'h010 || game_over !== 1'b0) $display("FAIL restart sel got %h/%b want 010/0", square_sel, game_over); else n_pass++;
  endtask

  task automatic test_back_to_back();
    new_game();
    cyc(0, 0, 1, 1, 1);
    n_total++; if (choice_en !== 1'b1) $display("FAIL coincide choice_en got %b want 1", choice_en); else n_pass++;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_total++; if (board_x !== 9'h010 || square_sel !== 9'h010) $display("FAIL coincide got bx %h sel %h want 010/010", board_x, square_sel); else n_pass++;
    new_game();
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    n_total++; if (board_x !== 9'd0 || start_en !== 1'b0) $display("FAIL rst-commit got bx %h en %b want 000/0", board_x, start_en); else n_pass++;
  endtask

  task automatic test_random();
    bit r, s, mr, md, cf;
    new_game();
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 14) == 0);
      mr = ($urandom_range(0, 2) == 0);
      md = ($urandom_range(0, 2) == 0);
      cf = ($urandom_range(0, 2) == 0);
      if (cf && m_phase == P_SEL && m_cell[m_cur] != 0) begin mr = 0; md = 0; end
      cyc(r, s, mr, md, cf);
      n_total++; if (board_x !== m_map(1)) $display("FAIL rand board_x c%0d got %h want %h", c, board_x, m_map(1)); else n_pass++;
      n_total++; if (board_o !== m_map(2)) $display("FAIL rand board_o c%0d got %h want %h", c, board_o, m_map(2)); else n_pass++;
      n_total++; if (winner !== 2'(m_win)) $display("FAIL rand winner c%0d got %b want %0d", c, winner, m_win); else n_pass++;
      n_total++; if (game_over !== (m_phase == P_DONE)) $display("FAIL rand game_over c%0d got %b", c, game_over); else n_pass++;
      n_total++; if (start_en !== (m_phase != P_IDLE)) $display("FAIL rand start_en c%0d got %b", c, start_en); else n_pass++;
      if (m_phase != P_CHECK) begin
        n_total++; if (choice_en !== (m_phase == P_COMMIT)) $display("FAIL rand choice_en c%0d got %b", c, choice_en); else n_pass++;
      end
      if (m_phase == P_SEL) begin
        n_total++; if (square_sel !== m_sel()) $display("FAIL rand square_sel c%0d got %h want %h", c, square_sel, m_sel()); else n_pass++;
        n_total++; if (square_color !== m_color()) $display("FAIL rand color c%0d got %h want %h", c, square_color, m_color()); else n_pass++;
      end else if (m_phase == P_IDLE || m_phase == P_DONE) begin
        n_total++; if (square_sel !== 9'd0) $display("FAIL rand idle/done sel c%0d got %h want 000", c, square_sel); else n_pass++;
      end
    end
  endtask

  initial begin
    m_new_game();
    m_phase = P_IDLE;
    test_reset();
    test_start();
    test_cursor_wrap();
    test_occupied();
    test_win();
    test_draw();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
